wb_mtimer: RTL and testbench



---
 rtl/mtimer_pkg.sv | 32 +++
 rtl/mtimer_prescaler.sv | 36 +++
 rtl/wb_mtimer.sv | 138 +++++++++++++
 tb/tb_wb_mtimer.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mtimer_pkg.sv
// Shared constants for the Wishbone machine timer: register word offsets,
// CTRL bit positions, reset defaults and the byte-lane merge helper.
package mtimer_pkg;

    localparam logic [2:0] MTIME_LO_OFS    = 3'd0;
    localparam logic [2:0] MTIME_HI_OFS    = 3'd1;
    localparam logic [2:0] MTIMECMP_LO_OFS = 3'd2;
    localparam logic [2:0] MTIMECMP_HI_OFS = 3'd3;
    localparam logic [2:0] CTRL_OFS        = 3'd4;
    localparam logic [2:0] PRESCALE_OFS    = 3'd5;

    localparam int CTRL_EN_BIT = 0;
    localparam int CTRL_IE_BIT = 1;

    localparam logic [31:0] PRESCALE_RESET_DEF = 32'd49;
    localparam logic [63:0] MTIMECMP_RESET_DEF = 64'hFFFF_FFFF_FFFF_FFFF;

    // Replace only the byte lanes selected by sel.
    function automatic logic [31:0] sel_merge(input logic [31:0] old_val,
                                              input logic [31:0] wdat,
                                              input logic [3:0]  sel);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) begin
                res[8*b +: 8] = wdat[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mtimer_prescaler.sv
// Divides sys_clk down to the mtime tick: one-cycle tick whenever the
// running count matches the programmed prescale value.
module mtimer_prescaler
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [31:0] prescale,
    input  logic        clr,
    output logic        tick
);

    logic [31:0] pcnt_q;
    logic [31:0] pcnt_d;

    always_comb begin
        tick   = en && (pcnt_q == prescale);
        pcnt_d = pcnt_q;
        if (clr) begin
            pcnt_d = '0;
        end else if (tick) begin
            pcnt_d = '0;
        end else if (en) begin
            pcnt_d = pcnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

endmodule

// File: rtl/wb_mtimer.sv
// RISC-V machine timer on a pipelined Wishbone slave port; holds mtime,
// mtimecmp, CTRL and PRESCALE and drives the level timer interrupt.
module wb_mtimer
    import mtimer_pkg::*;
#(
    parameter logic [31:0] PRESCALE_RESET = PRESCALE_RESET_DEF,
    parameter logic [63:0] MTIMECMP_RESET = MTIMECMP_RESET_DEF
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  wb_adr,
    input  logic [31:0] wb_dat_w,
    output logic [31:0] wb_dat_r,
    input  logic [3:0]  wb_sel,
    input  logic        wb_cyc,
    input  logic        wb_stb,
    input  logic        wb_we,
    output logic        wb_stall,
    output logic        wb_ack,
    output logic        wb_err,
    output logic        irq_timer
);

    logic [63:0] mtime_q,    mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic [1:0]  ctrl_q,     ctrl_d;
    logic [31:0] prescale_q, prescale_d;
    logic [31:0] shadow_q,   shadow_d;
    logic        ack_q,      ack_d;
    logic        err_q,      err_d;
    logic [31:0] dat_q,      dat_d;
    logic        irq_q,      irq_d;

    logic        req;
    logic        wr;
    logic        rd;
    logic        mapped;
    logic        tick;
    logic        pcnt_clr;
    logic [31:0] rdata;

    mtimer_prescaler u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .en       (ctrl_q[CTRL_EN_BIT]),
        .prescale (prescale_q),
        .clr      (pcnt_clr),
        .tick     (tick)
    );

    always_comb begin
        req      = wb_cyc && wb_stb;
        wr       = req && wb_we;
        rd       = req && !wb_we;
        mapped   = (wb_adr <= PRESCALE_OFS);
        pcnt_clr = wr && (wb_adr == PRESCALE_OFS);

        rdata = '0;
        case (wb_adr)
            MTIME_LO_OFS:    rdata = mtime_q[31:0];
            MTIME_HI_OFS:    rdata = shadow_q;
            MTIMECMP_LO_OFS: rdata = mtimecmp_q[31:0];
            MTIMECMP_HI_OFS: rdata = mtimecmp_q[63:32];
            CTRL_OFS:        rdata = {30'd0, ctrl_q};
            PRESCALE_OFS:    rdata = prescale_q;
            default:         rdata = '0;
        endcase

        // A bus write to either mtime half suppresses that cycle's increment.
        mtime_d = tick ? (mtime_q + 64'd1) : mtime_q;
        if (wr && (wb_adr == MTIME_LO_OFS)) begin
            mtime_d = {mtime_q[63:32], sel_merge(mtime_q[31:0], wb_dat_w, wb_sel)};
        end else if (wr && (wb_adr == MTIME_HI_OFS)) begin
            mtime_d = {sel_merge(mtime_q[63:32], wb_dat_w, wb_sel), mtime_q[31:0]};
        end

        mtimecmp_d = mtimecmp_q;
        if (wr && (wb_adr == MTIMECMP_LO_OFS)) begin
            mtimecmp_d[31:0] = sel_merge(mtimecmp_q[31:0], wb_dat_w, wb_sel);
        end
        if (wr && (wb_adr == MTIMECMP_HI_OFS)) begin
            mtimecmp_d[63:32] = sel_merge(mtimecmp_q[63:32], wb_dat_w, wb_sel);
        end

        ctrl_d = ctrl_q;
        if (wr && (wb_adr == CTRL_OFS) && wb_sel[0]) begin
            ctrl_d = wb_dat_w[1:0];
        end

        prescale_d = prescale_q;
        if (pcnt_clr) begin
            prescale_d = sel_merge(prescale_q, wb_dat_w, wb_sel);
        end

        // Latch the upper half on a low read so a LO/HI pair is coherent.
        shadow_d = shadow_q;
        if (rd && (wb_adr == MTIME_LO_OFS)) begin
            shadow_d = mtime_q[63:32];
        end

        ack_d = req && mapped;
        err_d = req && !mapped;
        dat_d = (req && mapped) ? rdata : 32'd0;
        irq_d = ctrl_q[CTRL_IE_BIT] && (mtime_q >= mtimecmp_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mtime_q    <= '0;
            mtimecmp_q <= MTIMECMP_RESET;
            ctrl_q     <= '0;
            prescale_q <= PRESCALE_RESET;
            shadow_q   <= '0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            dat_q      <= '0;
            irq_q      <= 1'b0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            ctrl_q     <= ctrl_d;
            prescale_q <= prescale_d;
            shadow_q   <= shadow_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            dat_q      <= dat_d;
            irq_q      <= irq_d;
        end
    end

    assign wb_stall  = 1'b0;
    assign wb_ack    = ack_q;
    assign wb_err    = err_q;
    assign wb_dat_r  = dat_q;
    assign irq_timer = irq_q;

endmodule

// File: tb/tb_wb_mtimer.sv
// Scoreboard bench for wb_mtimer: a cycle-level behavioural model queues the
// expected response of each request and a negedge monitor compares them.
module tb_wb_mtimer;

    logic        clk;
    logic        rst;
    logic [2:0]  wb_adr;
    logic [31:0] wb_dat_w;
    logic [31:0] wb_dat_r;
    logic [3:0]  wb_sel;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_we;
    logic        wb_stall;
    logic        wb_ack;
    logic        wb_err;
    logic        irq_timer;

    wb_mtimer dut (
        .clk       (clk),
        .rst       (rst),
        .wb_adr    (wb_adr),
        .wb_dat_w  (wb_dat_w),
        .wb_dat_r  (wb_dat_r),
        .wb_sel    (wb_sel),
        .wb_cyc    (wb_cyc),
        .wb_stb    (wb_stb),
        .wb_we     (wb_we),
        .wb_stall  (wb_stall),
        .wb_ack    (wb_ack),
        .wb_err    (wb_err),
        .irq_timer (irq_timer)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          ack;
        bit          err;
        bit          rd;
        bit [2:0]    adr;
        bit [31:0]   dat;
    } exp_t;

    exp_t exp_q[$];

    int checks;
    int errors;

    // Reference state, as software sees the timer.
    bit [63:0] m_mtime;
    bit [63:0] m_cmp;
    bit [31:0] m_pre;
    bit [31:0] m_pcnt;
    bit [31:0] m_shadow;
    bit        m_en;
    bit        m_ie;
    bit        m_irq;

    function automatic bit [31:0] merge(input bit [31:0] o, input bit [31:0] w, input bit [3:0] s);
        bit [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = w[8*b +: 8];
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_mtime  = 64'd0;
        m_cmp    = 64'hFFFF_FFFF_FFFF_FFFF;
        m_pre    = 32'd49;
        m_pcnt   = 32'd0;
        m_shadow = 32'd0;
        m_en     = 1'b0;
        m_ie     = 1'b0;
        m_irq    = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_step();
        bit        req;
        bit        wr;
        bit        tick;
        bit [63:0] n_mtime;
        bit [31:0] n_pcnt;
        exp_t      e;
        req  = wb_cyc && wb_stb;
        wr   = req && wb_we;
        tick = m_en && (m_pcnt == m_pre);
        n_mtime = tick ? m_mtime + 64'd1 : m_mtime;
        n_pcnt  = m_en ? (tick ? 32'd0 : m_pcnt + 32'd1) : m_pcnt;
        m_irq   = m_ie && (m_mtime >= m_cmp);
        if (req) begin
            e.adr = wb_adr;
            e.ack = (wb_adr < 3'd6);
            e.err = !e.ack;
            e.rd  = !wb_we;
            case (wb_adr)
                3'd0:    e.dat = m_mtime[31:0];
                3'd1:    e.dat = m_shadow;
                3'd2:    e.dat = m_cmp[31:0];
                3'd3:    e.dat = m_cmp[63:32];
                3'd4:    e.dat = {30'd0, m_ie, m_en};
                3'd5:    e.dat = m_pre;
                default: e.dat = 32'd0;
            endcase
            exp_q.push_back(e);
            if (!wb_we && wb_adr == 3'd0) m_shadow = m_mtime[63:32];
        end
        if (wr) begin
            case (wb_adr)
                3'd0: n_mtime = {m_mtime[63:32], merge(m_mtime[31:0], wb_dat_w, wb_sel)};
                3'd1: n_mtime = {merge(m_mtime[63:32], wb_dat_w, wb_sel), m_mtime[31:0]};
                3'd2: m_cmp[31:0]  = merge(m_cmp[31:0], wb_dat_w, wb_sel);
                3'd3: m_cmp[63:32] = merge(m_cmp[63:32], wb_dat_w, wb_sel);
                3'd4: if (wb_sel[0]) begin m_en = wb_dat_w[0]; m_ie = wb_dat_w[1]; end
                3'd5: begin m_pre = merge(m_pre, wb_dat_w, wb_sel); n_pcnt = 32'd0; end
                default: ;
            endcase
        end
        m_mtime = n_mtime;
        m_pcnt  = n_pcnt;
    endtask

    task automatic monitor_step();
        exp_t e;
        check("irq_timer", {31'd0, irq_timer}, {31'd0, m_irq});
        check("wb_stall", {31'd0, wb_stall}, 32'd0);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check($sformatf("ack adr%0d", e.adr), {31'd0, wb_ack}, {31'd0, e.ack});
            check($sformatf("err adr%0d", e.adr), {31'd0, wb_err}, {31'd0, e.err});
            if (e.rd) begin
                check($sformatf("dat_r adr%0d", e.adr), wb_dat_r, e.dat);
                $display("rd adr=%0d dat=%h exp=%h ack=%0b err=%0b", e.adr, wb_dat_r, e.dat, wb_ack, wb_err);
            end else begin
                $display("wr adr=%0d ack=%0b err=%0b", e.adr, wb_ack, wb_err);
            end
        end else begin
            check("unexpected response", {30'd0, wb_ack, wb_err}, 32'd0);
        end
    endtask

    task automatic xfer(input bit [2:0] a, input bit we, input bit [31:0] d, input bit [3:0] s);
        wb_cyc   = 1'b1;
        wb_stb   = 1'b1;
        wb_adr   = a;
        wb_we    = we;
        wb_dat_w = d;
        wb_sel   = s;
        @(negedge clk);
    endtask

    task automatic wr(input bit [2:0] a, input bit [31:0] d);
        xfer(a, 1'b1, d, 4'hF);
    endtask

    task automatic rd(input bit [2:0] a);
        xfer(a, 1'b0, 32'd0, 4'h0);
    endtask

    task automatic idle(input int n);
        wb_cyc = 1'b0;
        wb_stb = 1'b0;
        wb_we  = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        wb_cyc   = 1'b0;
        wb_stb   = 1'b0;
        wb_we    = 1'b0;
        wb_adr   = 3'd0;
        wb_dat_w = 32'd0;
        wb_sel   = 4'h0;
        model_reset();
        fork
            forever begin
                @(posedge clk or posedge rst);
                if (rst) model_reset();
                else     model_step();
            end
            forever begin
                @(negedge clk);
                if (!rst) monitor_step();
            end
        join_none

        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset values of all six registers, back-to-back.
        for (int i = 0; i < 6; i++) rd(i[2:0]);
        idle(2);

        // Free-running count at prescale 0, then prescale 4.
        wr(3'd5, 32'd0);
        wr(3'd4, 32'd1);
        idle(100);
        rd(3'd0);
        wr(3'd4, 32'd0);
        wr(3'd5, 32'd4);
        wr(3'd4, 32'd1);
        for (int i = 0; i < 10; i++) begin
            rd(3'd0);
            idle(4);
        end

        // Carry into the high word, read as LO/HI pairs around the wrap.
        wr(3'd4, 32'd0);
        wr(3'd5, 32'd0);
        wr(3'd0, 32'hFFFF_FFFC);
        wr(3'd1, 32'd0);
        wr(3'd4, 32'd1);
        for (int i = 0; i < 6; i++) begin
            rd(3'd0);
            rd(3'd1);
        end
        idle(1);

        // Interrupt assert at compare, drop on mtimecmp rewrite and on IE clear.
        wr(3'd4, 32'd0);
        wr(3'd2, 32'd10);
        wr(3'd3, 32'd0);
        wr(3'd0, 32'd0);
        wr(3'd1, 32'd0);
        wr(3'd5, 32'd0);
        wr(3'd4, 32'd3);
        idle(20);
        wr(3'd2, 32'd1000);
        idle(3);
        wr(3'd2, 32'd5);
        idle(3);
        wr(3'd4, 32'd1);
        idle(3);

        // Partial-byte write colliding with a tick, then unmapped accesses.
        xfer(3'd0, 1'b1, 32'h1234_5678, 4'b0011);
        rd(3'd0);
        rd(3'd6);
        rd(3'd7);
        xfer(3'd6, 1'b1, 32'hDEAD_BEEF, 4'hF);
        xfer(3'd2, 1'b1, 32'hFFFF_FFFF, 4'h0);
        rd(3'd2);
        idle(2);

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            bit [2:0]  a;
            bit [31:0] d;
            a = 3'($urandom_range(0, 7));
            d = (a == 3'd5) ? $urandom_range(0, 3) : $urandom;
            if ((a == 3'd2 || a == 3'd3) && $urandom_range(0, 1) == 1) d = $urandom_range(0, 64);
            xfer(a, 1'($urandom_range(0, 1)), d, 4'($urandom));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(2);

        // Asynchronous reset while irq is high and a request is on the bus.
        wr(3'd2, 32'd0);
        wr(3'd3, 32'd0);
        wr(3'd4, 32'd3);
        idle(3);
        wb_cyc = 1'b1;
        wb_stb = 1'b1;
        wb_we  = 1'b0;
        wb_adr = 3'd5;
        #2;
        rst = 1'b1;
        #1;
        check("async rst ack", {31'd0, wb_ack}, 32'd0);
        check("async rst err", {31'd0, wb_err}, 32'd0);
        check("async rst dat", wb_dat_r, 32'd0);
        check("async rst irq", {31'd0, irq_timer}, 32'd0);
        @(negedge clk);
        wb_cyc = 1'b0;
        wb_stb = 1'b0;
        rst    = 1'b0;
        idle(3);
        for (int i = 0; i < 6; i++) rd(i[2:0]);
        idle(3);

        check("pending responses left", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
